control: RTL and testbench

CONTROL -- requirements
Module: control

---
 rtl/control_pkg.sv | 27 ++
 rtl/control_alu.sv | 95 +++++++++
 rtl/control.sv | 73 +++++++
 tb/tb_control.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// control_pkg -- shared definitions for the accumulator control block.
// Holds the datapath width and the 4-bit opcode encoding used by
// control (register file + output port) and control_alu (next-state logic).
package control_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_AND  = 4'b0001,
        OP_OR   = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_MOVB = 4'b0100,
        OP_ADD  = 4'b0101,
        OP_IN   = 4'b0110,
        OP_SUB  = 4'b0111,
        OP_OUT  = 4'b1000,
        OP_CLR  = 4'b1001,
        OP_NOT  = 4'b1010,
        OP_SWAP = 4'b1011,
        OP_SHL  = 4'b1100,
        OP_SHR  = 4'b1101,
        OP_INC  = 4'b1110,
        OP_DEC  = 4'b1111
    } opcode_t;

endpackage

// File: rtl/control_alu.sv
// control_alu -- purely combinational next-state logic for control.
// Ports:
//   a, b      current accumulator / B register
//   portin    external data, consumed only by IN
//   opcode    instruction being executed this cycle
//   a_next    candidate new A (valid when a_we)
//   b_next    candidate new B (valid when b_we)
//   carry     candidate new carry flag (valid when c_we)
//   a_we      A is written (also means the zero flag is refreshed)
//   b_we      B is written
//   c_we      carry flag is written
//   out_we    output port loads the current A
module control_alu
    import control_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] portin,
    input  opcode_t           opcode,
    output logic [DATA_W-1:0] a_next,
    output logic [DATA_W-1:0] b_next,
    output logic              carry,
    output logic              a_we,
    output logic              b_we,
    output logic              c_we,
    output logic              out_we
);

    always_comb begin
        a_next = a;
        b_next = b;
        carry  = 1'b0;
        a_we   = 1'b0;
        b_we   = 1'b0;
        c_we   = 1'b0;
        out_we = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_AND: begin a_next = a & b; a_we = 1'b1; end
            OP_OR:  begin a_next = a | b; a_we = 1'b1; end
            OP_XOR: begin a_next = a ^ b; a_we = 1'b1; end
            OP_MOVB: begin b_next = a; b_we = 1'b1; end
            // Widened by one bit so the MSB of the sum is the carry out.
            OP_ADD: begin
                {carry, a_next} = {1'b0, a} + {1'b0, b};
                a_we = 1'b1;
                c_we = 1'b1;
            end
            OP_IN: begin a_next = portin; a_we = 1'b1; end
            // A negative widened difference sets the MSB, i.e. the borrow.
            OP_SUB: begin
                {carry, a_next} = {1'b0, a} - {1'b0, b};
                a_we = 1'b1;
                c_we = 1'b1;
            end
            OP_OUT: out_we = 1'b1;
            OP_CLR: begin
                a_next = '0;
                b_next = '0;
                carry  = 1'b0;
                a_we   = 1'b1;
                b_we   = 1'b1;
                c_we   = 1'b1;
            end
            OP_NOT: begin a_next = ~a; a_we = 1'b1; end
            OP_SWAP: begin
                a_next = b;
                b_next = a;
                a_we   = 1'b1;
                b_we   = 1'b1;
            end
            OP_SHL: begin
                {carry, a_next} = {a, 1'b0};
                a_we = 1'b1;
                c_we = 1'b1;
            end
            OP_SHR: begin
                {a_next, carry} = {1'b0, a};
                a_we = 1'b1;
                c_we = 1'b1;
            end
            OP_INC: begin
                {carry, a_next} = {1'b0, a} + {{DATA_W{1'b0}}, 1'b1};
                a_we = 1'b1;
                c_we = 1'b1;
            end
            OP_DEC: begin
                {carry, a_next} = {1'b0, a} - {{DATA_W{1'b0}}, 1'b1};
                a_we = 1'b1;
                c_we = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control.sv
// control -- single-cycle accumulator machine: one instruction per clock.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset (A=B=portout=cflag=0, zflag=1)
//   portin   external data read by IN
//   instr    opcode executed on each rising edge
//   portout  registered output port, loaded by OUT
//   zflag    A == 0 after the last instruction that wrote A
//   cflag    carry/borrow from the last ADD/SUB/INC/DEC/SHL/SHR (cleared by CLR)
module control #(
    parameter int DATA_W = control_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] portin,
    input  logic [3:0]        instr,
    output logic [DATA_W-1:0] portout,
    output logic              zflag,
    output logic              cflag
);
    import control_pkg::*;

    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_next;
    logic              carry_next;
    logic              a_we;
    logic              b_we;
    logic              c_we;
    logic              out_we;

    control_alu u_alu (
        .a      (a_reg),
        .b      (b_reg),
        .portin (portin),
        .opcode (opcode_t'(instr)),
        .a_next (a_next),
        .b_next (b_next),
        .carry  (carry_next),
        .a_we   (a_we),
        .b_we   (b_we),
        .c_we   (c_we),
        .out_we (out_we)
    );

    // SWAP is atomic because both registers load from values computed off
    // the pre-edge state in the same clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            portout <= '0;
            cflag   <= 1'b0;
            zflag   <= 1'b1;
        end else begin
            if (a_we) begin
                a_reg <= a_next;
                zflag <= (a_next == '0);
            end
            if (b_we) begin
                b_reg <= b_next;
            end
            if (c_we) begin
                cflag <= carry_next;
            end
            if (out_we) begin
                portout <= a_reg;
            end
        end
    end

endmodule

// File: tb/tb_control.sv
// tb_control -- self-checking bench for control: directed scenarios with
// literal expectations plus randomized instruction streams checked against
// an integer-arithmetic model every cycle.
module tb_control;

    logic       clk;
    logic       rst;
    logic [3:0] portin;
    logic [3:0] instr;
    logic [3:0] portout;
    logic       zflag;
    logic       cflag;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    // Model state as plain integers.
    int ma, mb, mout, mc, mz;

    control #(.DATA_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .portin  (portin),
        .instr   (instr),
        .portout (portout),
        .zflag   (zflag),
        .cflag   (cflag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int NOP = 0, AND_ = 1, OR_ = 2, XOR_ = 3, MOVB = 4, ADD = 5,
                   IN_ = 6, SUB = 7, OUT_ = 8, CLR = 9, NOT_ = 10, SWAP = 11,
                   SHL = 12, SHR = 13, INC = 14, DEC = 15;

    task automatic model_reset();
        ma = 0; mb = 0; mout = 0; mc = 0; mz = 1;
    endtask

    task automatic model_exec(input int op, input int pin);
        int t;
        case (op)
            AND_: ma = ma & mb;
            OR_:  ma = ma | mb;
            XOR_: ma = ma ^ mb;
            MOVB: mb = ma;
            ADD:  begin t = ma + mb; mc = (t > 15) ? 1 : 0; ma = t % 16; end
            IN_:  ma = pin;
            SUB:  begin mc = (ma < mb) ? 1 : 0; ma = (ma - mb + 16) % 16; end
            OUT_: mout = ma;
            CLR:  begin ma = 0; mb = 0; mc = 0; end
            NOT_: ma = 15 - ma;
            SWAP: begin t = ma; ma = mb; mb = t; end
            SHL:  begin mc = (ma >= 8) ? 1 : 0; ma = (ma * 2) % 16; end
            SHR:  begin mc = ma % 2; ma = ma / 2; end
            INC:  begin mc = (ma == 15) ? 1 : 0; ma = (ma + 1) % 16; end
            DEC:  begin mc = (ma == 0) ? 1 : 0; ma = (ma + 15) % 16; end
            default: ;
        endcase
        if (op != NOP && op != MOVB && op != OUT_) mz = (ma == 0) ? 1 : 0;
    endtask

    task automatic lit(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare process: outputs settle well before the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (int'(portout) != mout || int'(zflag) != mz || int'(cflag) != mc) begin
                fails++;
                $display("FAIL cycle_cmp t=%0t: got out=%0d z=%0d c=%0d expected out=%0d z=%0d c=%0d",
                         $time, portout, zflag, cflag, mout, mz, mc);
            end
        end
    end

    // Called at posedge+1; inputs are stable until the next edge.
    task automatic step(input int op, input int pin);
        instr  = 4'(op);
        portin = 4'(pin);
        @(posedge clk);
        model_exec(op, pin);
        #1;
        $display("[TB] t=%0t instr=%0d portin=%0d -> portout=%0d z=%0d c=%0d",
                 $time, op, pin, portout, zflag, cflag);
    endtask

    // Asynchronous reset pulse with instr churn while it is held.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        lit("rst_portout", int'(portout), 0);
        lit("rst_zflag", int'(zflag), 1);
        lit("rst_cflag", int'(cflag), 0);
        repeat (2) begin
            instr  = 4'($urandom_range(0, 15));
            portin = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        $display("[TB] t=%0t reset pulse done", $time);
    endtask

    initial begin
        rst = 1'b1; instr = 4'd0; portin = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        lit("init_portout", int'(portout), 0);
        lit("init_zflag", int'(zflag), 1);
        rst = 1'b0;
        chk_en = 1;

        // Reset with instr activity has no effect.
        step(IN_, 7); step(OUT_, 0);
        do_reset();
        lit("rst_pulse_portout", int'(portout), 0);

        // CLR / IN / MOVB / ADD / OUT
        step(CLR, 0); step(IN_, 3); step(MOVB, 0); step(IN_, 3); step(MOVB, 1);
        step(ADD, 0); step(OUT_, 0);
        lit("seq_add_out", int'(portout), 6);
        step(ADD, 0); step(NOP, 0); step(SUB, 0); step(OUT_, 0);
        lit("seq_sub_out", int'(portout), 6);

        // ADD wraparound then DEC of 0
        step(IN_, 15); step(MOVB, 0); step(IN_, 1); step(ADD, 0);
        lit("wrap_z", int'(zflag), 1);
        lit("wrap_c", int'(cflag), 1);
        step(OUT_, 0);
        lit("wrap_out", int'(portout), 0);
        step(DEC, 0);
        lit("dec0_c", int'(cflag), 1);
        step(OUT_, 0);
        lit("dec0_out", int'(portout), 15);

        // Shifts and SWAP with B=5
        step(IN_, 5); step(MOVB, 0); step(IN_, 9); step(SHL, 0);
        lit("shl_c", int'(cflag), 1);
        step(OUT_, 0);
        lit("shl_out", int'(portout), 2);
        step(SHR, 0);
        lit("shr_c", int'(cflag), 0);
        step(OUT_, 0);
        lit("shr_out", int'(portout), 1);
        step(SWAP, 0); step(OUT_, 0);
        lit("swap_a", int'(portout), 5);
        step(SWAP, 0); step(OUT_, 0);
        lit("swap_b", int'(portout), 1);

        // Logic ops with B=12
        step(IN_, 12); step(MOVB, 0); step(IN_, 10); step(AND_, 0); step(OUT_, 0);
        lit("and_out", int'(portout), 8);
        step(IN_, 10); step(OR_, 0); step(OUT_, 0);
        lit("or_out", int'(portout), 14);
        step(XOR_, 0); step(OUT_, 0);
        lit("xor_out", int'(portout), 2);
        step(NOT_, 0); step(OUT_, 0);
        lit("not_out", int'(portout), 13);

        // INC of 15, SUB with A==B
        step(IN_, 15); step(INC, 0);
        lit("inc15_z", int'(zflag), 1);
        lit("inc15_c", int'(cflag), 1);
        step(IN_, 7); step(MOVB, 0); step(SUB, 0);
        lit("subeq_z", int'(zflag), 1);
        lit("subeq_c", int'(cflag), 0);

        // Reset between ADD and OUT
        step(CLR, 0); step(IN_, 3); step(MOVB, 0); step(IN_, 3); step(ADD, 0);
        do_reset();
        lit("midrst_portout", int'(portout), 0);
        step(OUT_, 0);
        lit("midrst_out", int'(portout), 0);

        // Randomized stream with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            else step(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        @(negedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
